xbus_fetch_master: RTL and testbench
====================================

XBUS_FETCH_MASTER -- requirements
Module: xbus_fetch_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: output buffer depth in words, power of two, at least 2.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles to wait for ack per request.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that launches a fetch when idle.
REQ-006 base_addr  input  32  first word address, sampled on accepted start.
REQ-007 word_cnt  input  16  number of words to fetch, sampled on accepted start.
REQ-008 busy  output  1  high from accepted start until done or error.
REQ-009 done  output  1  one-cycle pulse when the last word is accepted downstream.
REQ-010 error  output  1  sticky ack-timeout flag, cleared by the next accepted start.
REQ-011 xbm_select  output  1  xbus request strobe.
REQ-012 xbm_addr  output  32  xbus word address.
REQ-013 xbm_data  output  32  xbus write data, constant 0.
REQ-014 xbm_rnw  output  1  constant 1 (read).
REQ-015 xbm_be  output  4  constant 4'hF.
REQ-016 xbm_ack  input  1  slave ack, one-cycle pulse.
REQ-017 xbm_rdata  input  32  slave read data, valid while xbm_ack is high.
REQ-018 dout  output  32  stream data at FIFO head.
REQ-019 dout_valid  output  1  FIFO not empty.
REQ-020 dout_ready  input  1  a word transfers on any cycle where dout_valid and dout_ready are both high.

Function
REQ-021 FSM states: IDLE, REQ, WAIT, DRAIN, ERR.
REQ-022 IDLE: start latches base_addr and word_cnt, clears error, and sets busy. The FSM then goes to DRAIN if word_cnt is 0, otherwise to REQ.
REQ-023 start is ignored in every state except IDLE and ERR.
REQ-024 REQ: when FIFO free slots are at least 1, xbm_select is high for exactly one cycle with xbm_addr equal to the current address, then the FSM goes to WAIT.
REQ-025 Only one request is outstanding at a time; xbm_select is never high in WAIT.
REQ-026 WAIT: on xbm_ack, xbm_rdata is written into the FIFO, the address increments by 1 with 32-bit wrap, and remaining decrements. The FSM goes to REQ if remaining is nonzero, else to DRAIN.
REQ-027 WAIT timeout counter: clears on entry and increments each cycle without ack. When it reaches TIMEOUT, error goes high, busy goes low, the FIFO flushes and the FSM goes to ERR.
REQ-028 DRAIN: once the FIFO is empty after the final transfer, done pulses for one cycle, busy falls in that same cycle, and the FSM goes to IDLE. A zero-word fetch pulses done on the cycle after start.
REQ-029 ERR: behaves as IDLE but keeps error high; an accepted start restarts the fetch.
REQ-030 FIFO: a simultaneous push and pop on a full or empty FIFO is legal and leaves the count consistent. Data reaches dout in order, with one cycle of latency from ack to dout_valid.
REQ-031 xbm_ack seen outside WAIT is ignored.

Reset
REQ-032 While rst is high, the following outputs are 0: busy, done, error, xbm_select, xbm_addr, dout_valid and dout. xbm_rnw is 1 and xbm_be is 4'hF.
REQ-033 Reset mid-fetch flushes the FIFO, clears all counters and returns the FSM to IDLE; a late ack arriving after reset is ignored.

Configuration
REQ-034 Macro XBUS_FETCH_BSWAP_EN.
- Defined: each captured word is byte-reversed before the FIFO write (rdata[7:0] becomes dout[31:24]).
- Undefined: words pass unchanged and no swap logic is built.

Structure
REQ-035 Package xbus_fetch_pkg holds the FSM state enum, the XBUS_BE_ALL constant (4'hF) and the word/address width constants.
REQ-036 Sub-module xbus_fetch_fifo: a synchronous FIFO with parameter DEPTH and ports push, pop, wdata, rdata, empty, full, count and flush.

Verification
REQ-037 base_addr=0x10, word_cnt=4, memory slave with delay 1, dout_ready held at 1 -> reads at 0x10..0x13; dout matches memory in order; one done pulse; busy low afterwards.
REQ-038 word_cnt=0 -> no xbm_select; done high on the cycle after start.
REQ-039 word_cnt=8, FIFO_DEPTH=4, dout_ready low -> exactly 4 requests and then a stall; raising ready delivers all 8 words in order.
REQ-040 Slave never acks, TIMEOUT=64 -> error high 64 cycles after the WAIT entry; busy low; a new start clears error.
REQ-041 rst asserted during the WAIT of word 2 -> outputs reach reset values; the late ack is ignored; a new fetch completes correctly.
REQ-042 With XBUS_FETCH_BSWAP_EN defined, memory word 0x11223344 -> dout equals 0x44332211.

Source files
------------

// File: rtl/xbus_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xbus_fetch_pkg
// Brief    : Shared widths, byte-enable constant and FSM encoding for the
//            xbus fetch master.
// Revision : 1.0 - initial release
// ============================================================================
package xbus_fetch_pkg;

    localparam int XBUS_ADDR_W = 32;
    localparam int XBUS_DATA_W = 32;
    localparam int XBUS_CNT_W  = 16;

    localparam logic [3:0] XBUS_BE_ALL = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/xbus_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : xbus_fetch_fifo
// Brief    : Synchronous FIFO with flush; rdata shows the head word, zero when
//            empty.
// Revision : 1.0 - initial release
// ============================================================================
module xbus_fetch_fifo
    import xbus_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [XBUS_DATA_W-1:0]       wdata,
    output logic [XBUS_DATA_W-1:0]       rdata,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [XBUS_DATA_W-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_cnt_w-1:0]     r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_depth);
    assign count = r_count;
    assign rdata = empty ? '0 : r_mem[r_rd_ptr];

    // A pop in the same cycle frees the slot a push on a full FIFO needs.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/xbus_fetch_master.sv
`default_nettype none
// ============================================================================
// Module   : xbus_fetch_master
// Brief    : Fetches word_cnt words over xbus, one request outstanding, and
//            streams them out through a FIFO. XBUS_FETCH_BSWAP_EN byte-reverses
//            each captured word.
// Revision : 1.0 - initial release
// ============================================================================
module xbus_fetch_master
    import xbus_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [XBUS_ADDR_W-1:0] base_addr,
    input  logic [XBUS_CNT_W-1:0]  word_cnt,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   xbm_select,
    output logic [XBUS_ADDR_W-1:0] xbm_addr,
    output logic [XBUS_DATA_W-1:0] xbm_data,
    output logic                   xbm_rnw,
    output logic [3:0]             xbm_be,
    input  logic                   xbm_ack,
    input  logic [XBUS_DATA_W-1:0] xbm_rdata,
    output logic [XBUS_DATA_W-1:0] dout,
    output logic                   dout_valid,
    input  logic                   dout_ready
);

    localparam int c_tmo_w = $clog2(TIMEOUT + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    fetch_state_t                  r_state;
    fetch_state_t                  w_next_state;
    logic [XBUS_ADDR_W-1:0]        r_addr;
    logic [XBUS_CNT_W-1:0]         r_remaining;
    logic [c_tmo_w-1:0]            r_tmo;
    logic                          r_error;

    logic                          w_accept_start;
    logic                          w_timeout;
    logic                          w_select;
    logic                          w_push;
    logic                          w_flush;
    logic                          w_done;
    logic                          w_busy;
    logic [XBUS_DATA_W-1:0]        w_wdata;
    logic                          w_fifo_empty;
    logic                          w_fifo_full;
    logic [$clog2(FIFO_DEPTH+1)-1:0] w_fifo_count;

    assign w_accept_start = start && (r_state == ST_IDLE || r_state == ST_ERR);
    assign w_timeout      = (r_state == ST_WAIT) && !xbm_ack && (r_tmo == c_tmo_last);

`ifdef XBUS_FETCH_BSWAP_EN
    assign w_wdata = {xbm_rdata[7:0], xbm_rdata[15:8], xbm_rdata[23:16], xbm_rdata[31:24]};
`else
    assign w_wdata = xbm_rdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (start) w_next_state = (word_cnt == '0) ? ST_DRAIN : ST_REQ;
            end
            ST_REQ: begin
                if (!w_fifo_full) w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (xbm_ack)        w_next_state = (r_remaining == 16'd1) ? ST_DRAIN : ST_REQ;
                else if (w_timeout) w_next_state = ST_ERR;
            end
            ST_DRAIN: begin
                if (w_fifo_count == '0) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_select = 1'b0;
        w_push   = 1'b0;
        w_flush  = 1'b0;
        w_done   = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            ST_REQ: begin
                w_busy   = 1'b1;
                w_select = !w_fifo_full;
            end
            ST_WAIT: begin
                w_busy  = 1'b1;
                w_push  = xbm_ack;
                w_flush = w_timeout;
            end
            ST_DRAIN: begin
                // Busy drops in the very cycle done pulses.
                w_done = (w_fifo_count == '0);
                w_busy = !w_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_tmo       <= '0;
            r_error     <= 1'b0;
        end else begin
            r_tmo <= ((r_state == ST_WAIT) && !xbm_ack) ? r_tmo + 1'b1 : '0;
            if (w_accept_start) begin
                r_addr      <= base_addr;
                r_remaining <= word_cnt;
                r_error     <= 1'b0;
            end else if ((r_state == ST_WAIT) && xbm_ack) begin
                r_addr      <= r_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end else if (w_timeout) begin
                r_error     <= 1'b1;
            end
        end
    end

    xbus_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (w_flush),
        .push  (w_push),
        .pop   (dout_valid && dout_ready),
        .wdata (w_wdata),
        .rdata (dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full),
        .count (w_fifo_count)
    );

    assign busy       = w_busy;
    assign done       = w_done;
    assign error      = r_error;
    assign xbm_select = w_select;
    assign xbm_addr   = r_addr;
    assign xbm_data   = '0;
    assign xbm_rnw    = 1'b1;
    assign xbm_be     = XBUS_BE_ALL;
    assign dout_valid = !w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_xbus_fetch_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_xbus_fetch_master
// Brief    : Scoreboard bench: expected request addresses and stream words are
//            queued by the directed tests and checked by independent monitors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xbus_fetch_master;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_cnt;
    logic        busy;
    logic        done;
    logic        error;
    logic        xbm_select;
    logic [31:0] xbm_addr;
    logic [31:0] xbm_data;
    logic        xbm_rnw;
    logic [3:0]  xbm_be;
    logic        xbm_ack;
    logic [31:0] xbm_rdata;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;

    int checks   = 0;
    int failures = 0;
    int req_cnt  = 0;
    int done_cnt = 0;
    int slave_delay = 1;
    bit slave_on    = 1'b1;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    xbus_fetch_master #(
        .FIFO_DEPTH (4),
        .TIMEOUT    (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_cnt   (word_cnt),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .xbm_select (xbm_select),
        .xbm_addr   (xbm_addr),
        .xbm_data   (xbm_data),
        .xbm_rnw    (xbm_rnw),
        .xbm_be     (xbm_be),
        .xbm_ack    (xbm_ack),
        .xbm_rdata  (xbm_rdata),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h1122_3344;
        return {16'hDEAD, a[15:0]};
    endfunction

    // Memory slave: ack slave_delay cycles after a request is seen.
    initial begin
        logic [31:0] a;
        xbm_ack   = 1'b0;
        xbm_rdata = '0;
        forever begin
            @(negedge clk);
            if (xbm_select && slave_on && !rst) begin
                a = xbm_addr;
                repeat (slave_delay) @(posedge clk);
                #1;
                xbm_ack   = 1'b1;
                xbm_rdata = mem_word(a);
                @(posedge clk);
                #1;
                xbm_ack   = 1'b0;
                xbm_rdata = '0;
            end
        end
    end

    // Request monitor.
    initial begin
        logic prev_sel;
        logic [31:0] e;
        prev_sel = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && xbm_select) begin
                req_cnt++;
                if (prev_sel) check("select_single_cycle", 32'(prev_sel), 32'd0);
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_request", xbm_addr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_addr_q.pop_front();
                    check("req_addr", xbm_addr, e);
                end
            end
            prev_sel = xbm_select;
        end
    end

    // Stream monitor.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && dout_valid && dout_ready) begin
                if (exp_data_q.size() == 0) begin
                    check("unexpected_word", dout, 32'hFFFF_FFFF);
                end else begin
                    e = exp_data_q.pop_front();
                    check("dout_word", dout, e);
                end
            end
            if (!rst && done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = b;
        word_cnt  = n;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        check("done_seen", 32'(done), 32'd1);
        check("busy_low_at_done", 32'(busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_error"},      32'(error),      32'd0);
        check({tag, "_select"},     32'(xbm_select), 32'd0);
        check({tag, "_addr"},       xbm_addr,        32'd0);
        check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_dout"},       dout,            32'd0);
        check({tag, "_rnw"},        32'(xbm_rnw),    32'd1);
        check({tag, "_be"},         32'(xbm_be),     32'hF);
        check({tag, "_wdata"},      xbm_data,        32'd0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_addr_q_left"}, 32'(exp_addr_q.size()), 32'd0);
        check({tag, "_data_q_left"}, 32'(exp_data_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        int req0;
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        word_cnt   = '0;
        dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Four-word fetch, delay-1 slave, sink always ready.
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back(32'h0000_0010 + 32'(i));
            exp_data_q.push_back(32'hDEAD_0010 + 32'(i));
        end
        done_cnt = 0;
        pulse_start(32'h0000_0010, 16'd4);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done(100);
        repeat (2) @(negedge clk);
        check("t1_done_pulses", 32'(done_cnt), 32'd1);
        check("t1_busy_after", 32'(busy), 32'd0);
        check_drained("t1");

        // Zero-word fetch.
        req0     = req_cnt;
        done_cnt = 0;
        pulse_start(32'h0000_0055, 16'd0);
        @(negedge clk);
        check("t2_done_next_cycle", 32'(done), 32'd1);
        @(negedge clk);
        check("t2_done_one_cycle", 32'(done), 32'd0);
        check("t2_no_requests", 32'(req_cnt - req0), 32'd0);
        check("t2_done_pulses", 32'(done_cnt), 32'd1);

        // Backpressure: FIFO fills after 4 requests, then drains in order.
        for (int i = 0; i < 8; i++) begin
            exp_addr_q.push_back(32'h0000_0040 + 32'(i));
            exp_data_q.push_back(32'hDEAD_0040 + 32'(i));
        end
        dout_ready = 1'b0;
        req0       = req_cnt;
        pulse_start(32'h0000_0040, 16'd8);
        repeat (30) @(negedge clk);
        check("t3_stalled_requests", 32'(req_cnt - req0), 32'd4);
        check("t3_head_valid", 32'(dout_valid), 32'd1);
        check("t3_head_word", dout, 32'hDEAD_0040);
        check("t3_still_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        wait_done(200);
        check_drained("t3");

        // Ack timeout.
        slave_on = 1'b0;
        done_cnt = 0;
        exp_addr_q.push_back(32'h0000_0080);
        pulse_start(32'h0000_0080, 16'd2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!xbm_select && n < 20);
        check("t4_request_seen", 32'(xbm_select), 32'd1);
        repeat (64) @(negedge clk);
        check("t4_error_not_early", 32'(error), 32'd0);
        @(negedge clk);
        check("t4_error_set", 32'(error), 32'd1);
        check("t4_busy_low", 32'(busy), 32'd0);
        check("t4_fifo_empty", 32'(dout_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_error_sticky", 32'(error), 32'd1);
        check("t4_no_done", 32'(done_cnt), 32'd0);
        slave_on = 1'b1;
        exp_addr_q.push_back(32'h0000_0090);
        exp_data_q.push_back(32'hDEAD_0090);
        pulse_start(32'h0000_0090, 16'd1);
        @(negedge clk);
        check("t4_error_cleared", 32'(error), 32'd0);
        wait_done(100);
        check_drained("t4");

        // Reset during the wait for word 2; the late ack must be ignored.
        slave_delay = 4;
        done_cnt    = 0;
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back(32'h0000_0020 + 32'(i));
            exp_data_q.push_back(32'hDEAD_0020 + 32'(i));
        end
        req0 = req_cnt;
        pulse_start(32'h0000_0020, 16'd4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((req_cnt - req0) < 2 && n < 50);
        check("t5_second_request", 32'(req_cnt - req0), 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        repeat (6) @(negedge clk);
        check("t5_late_ack_no_data", 32'(dout_valid), 32'd0);
        check("t5_late_ack_idle", 32'(busy), 32'd0);
        check("t5_no_done", 32'(done_cnt), 32'd0);
        slave_delay = 1;
        exp_addr_q.push_back(32'h0000_0030);
        exp_addr_q.push_back(32'h0000_0031);
        exp_data_q.push_back(32'hDEAD_0030);
        exp_data_q.push_back(32'hDEAD_0031);
        pulse_start(32'h0000_0030, 16'd2);
        wait_done(100);
        check_drained("t5");

        // Byte order of a distinctive word.
        exp_addr_q.push_back(32'h0000_0100);
`ifdef XBUS_FETCH_BSWAP_EN
        exp_data_q.push_back(32'h4433_2211);
`else
        exp_data_q.push_back(32'h1122_3344);
`endif
        pulse_start(32'h0000_0100, 16'd1);
        wait_done(100);
        check_drained("t6");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
